timer_supervisor: RTL

- Initiator side of the seconds-timer interface: drives the timer's level-sensitive `active` input and consumes its `done` level.
- Converts a one-cycle start request from the control FSM into an armed timer session and counts `done` rising edges up to a programmed number of periods.
- Emits a one-cycle `expired` pulse, and raises `fault` if the timer stops producing `done` edges.
- Sits between the main control FSM and the timer instance.

---
 rtl/timer_supervisor_pkg.sv | 14 +
 rtl/timer_supervisor_edge_rise_det.sv | 29 ++
 rtl/timer_supervisor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/timer_supervisor_pkg.sv
// Shared types and defaults for the seconds-timer supervisor.
package timer_supervisor_pkg;

   localparam int unsigned PW_DEF          = 4;
   localparam int unsigned FAULT_LIMIT_DEF = 1023;
   localparam int unsigned WDW_DEF         = 10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ARMED = 2'b01,
      S_FAULT = 2'b10
   } state_e;

endpackage : timer_supervisor_pkg

// File: rtl/timer_supervisor_edge_rise_det.sv
// Rising-edge detector on the timer done level; the arm cycle never reports an edge.
module edge_rise_det (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   input  logic load_i,
   output logic rise_c
);

   logic done_q;
   logic done_d;

   // Loading on arm snapshots the current level, which is the normal tracking path.
   always_comb begin
      done_d = level_i;
   end

   // Previous-level register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign rise_c = level_i & ~done_q & ~load_i;

endmodule : edge_rise_det

// File: rtl/timer_supervisor.sv
// Initiator side of the seconds-timer interface: arms the timer, counts done
// edges up to a programmed number of periods, and watches for a stalled timer.
module timer_supervisor
   import timer_supervisor_pkg::*;
#(
   parameter int unsigned PW          = PW_DEF,
   parameter int unsigned FAULT_LIMIT = FAULT_LIMIT_DEF,
   parameter int unsigned WDW         = WDW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          cancel,
   input  logic [PW-1:0] periods,
   input  logic          timer_done,
   output logic          timer_active,
   output logic          busy,
   output logic          expired,
   output logic          fault,
   output logic [PW-1:0] elapsed
);

   localparam logic [WDW-1:0] WD_LAST = WDW'(FAULT_LIMIT - 1);

   state_e         state_q,   state_d;
   logic           active_q,  active_d;
   logic           busy_q,    busy_d;
   logic           expired_q, expired_d;
   logic           fault_q,   fault_d;
   logic [PW-1:0]  elapsed_q, elapsed_d;
   logic [PW-1:0]  target_q,  target_d;
   logic [WDW-1:0] wd_q,      wd_d;

   logic           arm_c;
   logic           rise_c;
   logic [PW-1:0]  load_target_c;
   logic [PW-1:0]  elapsed_inc_c;

   // An accepted start (never together with cancel) arms from any state.
   assign arm_c         = start & ~cancel;
   assign load_target_c = (periods == '0) ? PW'(1) : periods;
   assign elapsed_inc_c = elapsed_q + PW'(1);

   edge_rise_det u_edge (
      .clk     (clk),
      .reset   (reset),
      .level_i (timer_done),
      .load_i  (arm_c),
      .rise_c  (rise_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      busy_d    = busy_q;
      expired_d = 1'b0;
      fault_d   = fault_q;
      elapsed_d = elapsed_q;
      target_d  = target_q;
      wd_d      = wd_q;

      unique case (state_q)
         S_IDLE: begin
            // Only arming leaves IDLE; handled below.
         end
         S_ARMED: begin
            if (cancel) begin
               state_d  = S_IDLE;
               active_d = 1'b0;
               busy_d   = 1'b0;
            end else if (start) begin
               // Re-arm handled below; a coincident edge is dropped.
            end else if (rise_c) begin
               elapsed_d = elapsed_inc_c;
               wd_d      = '0;
               if (elapsed_inc_c == target_q) begin
                  state_d   = S_IDLE;
                  expired_d = 1'b1;
                  active_d  = 1'b0;
                  busy_d    = 1'b0;
               end
            end else if (wd_q == WD_LAST) begin
               state_d  = S_FAULT;
               active_d = 1'b0;
               busy_d   = 1'b0;
               fault_d  = 1'b1;
               wd_d     = '0;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         S_FAULT: begin
            if (cancel) begin
               state_d = S_IDLE;
               fault_d = 1'b0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            active_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase

      if (arm_c) begin
         state_d   = S_ARMED;
         active_d  = 1'b1;
         busy_d    = 1'b1;
         fault_d   = 1'b0;
         target_d  = load_target_c;
         elapsed_d = '0;
         wd_d      = '0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         active_q  <= 1'b0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
         fault_q   <= 1'b0;
         elapsed_q <= '0;
         target_q  <= '0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         busy_q    <= busy_d;
         expired_q <= expired_d;
         fault_q   <= fault_d;
         elapsed_q <= elapsed_d;
         target_q  <= target_d;
         wd_q      <= wd_d;
      end
   end

   assign timer_active = active_q;
   assign busy         = busy_q;
   assign expired      = expired_q;
   assign fault        = fault_q;
   assign elapsed      = elapsed_q;

endmodule : timer_supervisor
